if_stage: RTL and testbench

Instruction-fetch stage of the 5-stage MIPS core. It owns the PC register and drives chip-enable and address to the combinational instruction ROM. It captures the returned word into the IF/ID pipeline register for the decode stage. It also applies hazard-unit stalls and branch/jump redirects resolved in ID.

---
 rtl/if_stage_pkg.sv | 25 ++
 rtl/if_stage_if.sv | 22 ++
 rtl/if_stage_pc_reg.sv | 43 ++++
 rtl/if_stage.sv | 52 +++++
 tb/tb_if_stage.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/if_stage_pkg.sv
// Shared constants and types for the instruction-fetch stage and its neighbours.
`ifndef IF_STAGE_DEFS
`define IF_STAGE_DEFS
`define RomEnable  1'b1
`define RomDisable 1'b0
`define Zero       32'h0
`endif

package if_stage_pkg;

  localparam logic        ROM_ENABLE   = `RomEnable;
  localparam logic        ROM_DISABLE  = `RomDisable;
  localparam logic [31:0] ZERO_WORD    = `Zero;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  // sll r0,r0,0
  localparam logic [31:0] NOP_INST_DEF = 32'h0000_0000;
  localparam logic [31:0] WORD_MASK    = 32'hFFFF_FFFC;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        valid;
  } ifid_t;

endpackage

// File: rtl/if_stage_if.sv
// Fetch-stage bus: ROM request/response, hazard/redirect controls, IF/ID outputs.
interface if_stage_if;
  logic        rom_ce;
  logic [31:0] rom_addr;
  logic [31:0] rom_data;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_addr;
  logic [31:0] id_pc;
  logic [31:0] id_inst;
  logic        id_valid;

  modport master (
    output rom_ce, rom_addr, id_pc, id_inst, id_valid,
    input  rom_data, stall, branch_taken, branch_addr
  );

  modport slave (
    input  rom_ce, rom_addr, id_pc, id_inst, id_valid,
    output rom_data, stall, branch_taken, branch_addr
  );
endinterface

// File: rtl/if_stage_pc_reg.sv
// PC register, ROM enable register and next-PC selection (hold / redirect / +4).
module if_stage_pc_reg
  import if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_addr,
  output logic [31:0] pc,
  output logic        rom_ce
);

  logic [31:0] pc_q, pc_d;
  logic        rom_ce_q, rom_ce_d;

  // Next PC: frozen until the ROM is enabled, then stall > redirect > sequential.
  always_comb begin
    rom_ce_d = ROM_ENABLE;
    pc_d     = pc_q;
    if (rom_ce_q == ROM_ENABLE && !stall) begin
      if (branch_taken) pc_d = branch_addr & WORD_MASK;
      else              pc_d = pc_q + 32'd4;
    end
  end

  // PC and ROM enable registers; reset is asynchronous, active-low.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q     <= RESET_PC;
      rom_ce_q <= ROM_DISABLE;
    end else begin
      pc_q     <= pc_d;
      rom_ce_q <= rom_ce_d;
    end
  end

  assign pc     = pc_q;
  assign rom_ce = rom_ce_q;

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: drives the ROM from the PC and fills the IF/ID register.
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter logic [31:0] NOP_INST = NOP_INST_DEF
) (
  input logic         clk,
  input logic         rst,
  if_stage_if.master  bus
);

  logic [31:0] pc;
  logic        rom_ce;
  ifid_t       ifid_q, ifid_d;

  if_stage_pc_reg #(
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk          (clk),
    .rst          (rst),
    .stall        (bus.stall),
    .branch_taken (bus.branch_taken),
    .branch_addr  (bus.branch_addr),
    .pc           (pc),
    .rom_ce       (rom_ce)
  );

  // IF/ID next value: bubble while the ROM is off or on a redirect, hold on stall.
  always_comb begin
    ifid_d = ifid_q;
    if (rom_ce != ROM_ENABLE) begin
      ifid_d = '{pc: ZERO_WORD, inst: NOP_INST, valid: 1'b0};
    end else if (!bus.stall) begin
      if (bus.branch_taken) ifid_d = '{pc: ZERO_WORD, inst: NOP_INST, valid: 1'b0};
      else                  ifid_d = '{pc: pc, inst: bus.rom_data, valid: 1'b1};
    end
  end

  // IF/ID pipeline register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ifid_q <= '{pc: ZERO_WORD, inst: NOP_INST, valid: 1'b0};
    else      ifid_q <= ifid_d;
  end

  assign bus.rom_ce   = rom_ce;
  assign bus.rom_addr = pc;
  assign bus.id_pc    = ifid_q.pc;
  assign bus.id_inst  = ifid_q.inst;
  assign bus.id_valid = ifid_q.valid;

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage with a cycle-level reference model.
module tb_if_stage;

  localparam logic [31:0] NOP = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall = 1'b0;
  logic        br = 1'b0;
  logic [31:0] br_addr = 32'h0;
  logic [31:0] rom_key = 32'h0;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state (architectural view of the fetch stage).
  logic [31:0] m_pc, m_id_pc, m_inst;
  logic        m_valid, m_ce;

  if_stage_if bus ();

  assign bus.stall        = stall;
  assign bus.branch_taken = br;
  assign bus.branch_addr  = br_addr;
  assign bus.rom_data     = (bus.rom_addr >> 2) ^ rom_key;

  if_stage dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rom_ref(input logic [31:0] a);
    return (a >> 2) ^ rom_key;
  endfunction

  task automatic model_reset();
    m_pc = 32'h0; m_id_pc = 32'h0; m_inst = NOP; m_valid = 1'b0; m_ce = 1'b0;
  endtask

  // One clock edge; the model applies the fetch rules to the pre-edge inputs.
  task automatic step();
    logic [31:0] n_pc, n_ipc, n_inst;
    logic        n_v;
    n_pc = m_pc; n_ipc = m_id_pc; n_inst = m_inst; n_v = m_valid;
    if (!m_ce) begin
      n_ipc = 32'h0; n_inst = NOP; n_v = 1'b0;
    end else if (stall) begin
      n_v = m_valid;
    end else if (br) begin
      n_pc = {br_addr[31:2], 2'b00}; n_ipc = 32'h0; n_inst = NOP; n_v = 1'b0;
    end else begin
      n_inst = rom_ref(m_pc); n_ipc = m_pc; n_v = 1'b1; n_pc = m_pc + 32'd4;
    end
    @(posedge clk);
    m_pc = n_pc; m_id_pc = n_ipc; m_inst = n_inst; m_valid = n_v; m_ce = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    #12;
    n_checks++;
    if (bus.rom_ce !== 1'b0) begin n_fail++; $display("FAIL reset_ce: got %b want 0", bus.rom_ce); end
    n_checks++;
    if (bus.rom_addr !== 32'h0) begin n_fail++; $display("FAIL reset_addr: got %h want 0", bus.rom_addr); end
    n_checks++;
    if ({bus.id_valid, bus.id_inst, bus.id_pc} !== {1'b0, NOP, 32'h0}) begin
      n_fail++; $display("FAIL reset_ifid: got v=%b i=%h pc=%h want 0/%h/0", bus.id_valid, bus.id_inst, bus.id_pc, NOP);
    end
    rst = 1'b1;
    model_reset();
    step();
    n_checks++;
    if (bus.rom_ce !== 1'b1 || bus.rom_addr !== 32'h0 || bus.id_valid !== 1'b0) begin
      n_fail++; $display("FAIL first_edge: got ce=%b addr=%h v=%b want 1/0/0", bus.rom_ce, bus.rom_addr, bus.id_valid);
    end
  endtask

  task automatic test_seq_fetch();
    for (int k = 0; k < 4; k++) begin
      step();
      n_checks++;
      if (bus.rom_addr !== 32'(4 * (k + 1)) || bus.id_inst !== 32'(k) ||
          bus.id_pc !== 32'(4 * k) || bus.id_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL seq_%0d: got addr=%h inst=%h pc=%h v=%b want %h/%h/%h/1",
                 k, bus.rom_addr, bus.id_inst, bus.id_pc, bus.id_valid, 4 * (k + 1), k, 4 * k);
      end
    end
  endtask

  task automatic test_stall();
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      n_checks++;
      if (bus.rom_addr !== 32'h10 || bus.id_inst !== 32'h3 || bus.id_pc !== 32'hC) begin
        n_fail++; $display("FAIL stall_%0d: got addr=%h inst=%h pc=%h want 10/3/c", k, bus.rom_addr, bus.id_inst, bus.id_pc);
      end
    end
    stall = 1'b0;
    step();
    n_checks++;
    if (bus.rom_addr !== 32'h14 || bus.id_pc !== 32'h10 || bus.id_inst !== 32'h4) begin
      n_fail++; $display("FAIL stall_resume: got addr=%h pc=%h inst=%h want 14/10/4", bus.rom_addr, bus.id_pc, bus.id_inst);
    end
  endtask

  task automatic advance_to(input logic [31:0] target);
    for (int k = 0; k < 64 && bus.rom_addr !== target; k++) step();
    n_checks++;
    if (bus.rom_addr !== target) begin n_fail++; $display("FAIL advance: got %h want %h", bus.rom_addr, target); end
  endtask

  task automatic test_branch();
    advance_to(32'h30);
    br = 1'b1; br_addr = 32'h10;
    step();
    br = 1'b0;
    n_checks++;
    if (bus.rom_addr !== 32'h10 || bus.id_inst !== NOP || bus.id_valid !== 1'b0) begin
      n_fail++; $display("FAIL branch_bubble: got addr=%h inst=%h v=%b want 10/%h/0", bus.rom_addr, bus.id_inst, bus.id_valid, NOP);
    end
    step();
    n_checks++;
    if (bus.id_pc !== 32'h10 || bus.id_valid !== 1'b1 || bus.id_inst !== 32'h4) begin
      n_fail++; $display("FAIL branch_target: got pc=%h v=%b inst=%h want 10/1/4", bus.id_pc, bus.id_valid, bus.id_inst);
    end
  endtask

  task automatic test_stall_branch();
    advance_to(32'h20);
    stall = 1'b1; br = 1'b1; br_addr = 32'h40;
    step(); step();
    n_checks++;
    if (bus.rom_addr !== 32'h20 || bus.id_valid !== 1'b1 || bus.id_pc !== 32'h1C) begin
      n_fail++; $display("FAIL stall_over_branch: got addr=%h v=%b pc=%h want 20/1/1c", bus.rom_addr, bus.id_valid, bus.id_pc);
    end
    stall = 1'b0;
    step();
    br = 1'b0;
    n_checks++;
    if (bus.rom_addr !== 32'h40 || bus.id_valid !== 1'b0) begin
      n_fail++; $display("FAIL stall_release_branch: got addr=%h v=%b want 40/0", bus.rom_addr, bus.id_valid);
    end
    step();
    n_checks++;
    if (bus.id_pc !== 32'h40 || bus.id_valid !== 1'b1) begin
      n_fail++; $display("FAIL stall_branch_target: got pc=%h v=%b want 40/1", bus.id_pc, bus.id_valid);
    end
  endtask

  task automatic test_misaligned();
    br = 1'b1; br_addr = 32'h13;
    step();
    br = 1'b0;
    n_checks++;
    if (bus.rom_addr !== 32'h10) begin n_fail++; $display("FAIL misaligned: got %h want 10", bus.rom_addr); end
  endtask

  task automatic test_wrap();
    br = 1'b1; br_addr = 32'hFFFF_FFFC;
    step();
    br = 1'b0;
    step();
    n_checks++;
    if (bus.rom_addr !== 32'h0 || bus.id_pc !== 32'hFFFF_FFFC || bus.id_inst !== 32'h3FFF_FFFF) begin
      n_fail++; $display("FAIL wrap: got addr=%h pc=%h inst=%h want 0/fffffffc/3fffffff", bus.rom_addr, bus.id_pc, bus.id_inst);
    end
  endtask

  task automatic test_async_reset();
    step(); step();
    #2 rst = 1'b0;
    #1;
    model_reset();
    n_checks++;
    if (bus.rom_addr !== 32'h0 || bus.rom_ce !== 1'b0 || bus.id_valid !== 1'b0 || bus.id_inst !== NOP) begin
      n_fail++; $display("FAIL async_reset: got addr=%h ce=%b v=%b inst=%h want 0/0/0/%h", bus.rom_addr, bus.rom_ce, bus.id_valid, bus.id_inst, NOP);
    end
    @(posedge clk); #3;
    rst = 1'b1;
    step();
    n_checks++;
    if (bus.rom_ce !== 1'b1 || bus.rom_addr !== 32'h0 || bus.id_valid !== 1'b0) begin
      n_fail++; $display("FAIL rst_ce_rise: got ce=%b addr=%h v=%b want 1/0/0", bus.rom_ce, bus.rom_addr, bus.id_valid);
    end
    step();
    n_checks++;
    if (bus.rom_addr !== 32'h4 || bus.id_pc !== 32'h0 || bus.id_valid !== 1'b1) begin
      n_fail++; $display("FAIL rst_refetch: got addr=%h pc=%h v=%b want 4/0/1", bus.rom_addr, bus.id_pc, bus.id_valid);
    end
  endtask

  task automatic test_random();
    rom_key = $urandom;
    for (int k = 0; k < 400; k++) begin
      stall   = ($urandom_range(0, 9) < 3);
      br      = ($urandom_range(0, 9) < 2);
      br_addr = $urandom;
      step();
      n_checks++;
      if (bus.rom_ce !== m_ce || bus.rom_addr !== m_pc) begin
        n_fail++; $display("FAIL rand_pc_%0d: got ce=%b addr=%h want %b/%h", k, bus.rom_ce, bus.rom_addr, m_ce, m_pc);
      end
      n_checks++;
      if (bus.id_valid !== m_valid || bus.id_inst !== m_inst) begin
        n_fail++; $display("FAIL rand_ifid_%0d: got v=%b inst=%h want %b/%h", k, bus.id_valid, bus.id_inst, m_valid, m_inst);
      end
      if (m_valid) begin
        n_checks++;
        if (bus.id_pc !== m_id_pc) begin
          n_fail++; $display("FAIL rand_idpc_%0d: got %h want %h", k, bus.id_pc, m_id_pc);
        end
      end
    end
    stall = 1'b0; br = 1'b0;
  endtask

  initial begin
    test_reset();
    test_seq_fetch();
    test_stall();
    test_branch();
    test_stall_branch();
    test_misaligned();
    test_wrap();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
